// File: rtl/pipe_pkg.sv
// Shared types for the 5-stage pipeline hazard logic: tracker entry, hazard mode, x0 constant.
package pipe_pkg;

    localparam logic [4:0] REG_X0 = 5'd0;
    localparam int         TRK_W  = 6;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
    } trk_entry_t;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_STALL,
        HZ_FLUSH,
        HZ_HOLD
    } hz_mode_e;

    function automatic logic rd_hit(input trk_entry_t e, input logic [4:0] rs);
        return e.vld && (e.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_trk.sv
// Shift tracker of destination registers in flight (index 0 = EX), with hold, bubble and insert controls.
module hazard_trk
    import pipe_pkg::*;
#(
    parameter int NUM_TRK = 3
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_hold,
    input  logic                       i_bubble,
    input  trk_entry_t                 i_ins,
    output logic [NUM_TRK*TRK_W-1:0]   o_entries
);

    trk_entry_t [NUM_TRK-1:0] entries_q;
    trk_entry_t [NUM_TRK-1:0] entries_d;

    always_comb begin
        entries_d = entries_q;
        if (!i_hold) begin
            entries_d[0] = i_bubble ? trk_entry_t'('0) : i_ins;
            for (int k = 1; k < NUM_TRK; k++) begin
                entries_d[k] = entries_q[k-1];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            entries_q <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

    assign o_entries = entries_q;

endmodule

// File: rtl/hazard_ctrl.sv
// RAW-stall / branch-flush / memory-hold control for the non-forwarding RV32I pipeline.
// Define HAZARD_PERF_EN to add STALL/FLUSH/HOLD cycle counters with a synchronous clear.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter bit WB_WRITE_FIRST = 1'b1,
    parameter int NUM_TRK        = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [4:0]  i_rs1_addr_id,
    input  logic [4:0]  i_rs2_addr_id,
    input  logic        i_rs1_use_id,
    input  logic        i_rs2_use_id,
    input  logic [4:0]  i_rd_addr_id,
    input  logic        i_rd_wren_id,
    input  logic        i_pc_sel_ex,
    input  logic        i_mem_wait,
`ifdef HAZARD_PERF_EN
    input  logic        i_perf_clr,
    output logic [31:0] o_raw_cycles,
    output logic [31:0] o_flush_cycles,
    output logic [31:0] o_hold_cycles,
`endif
    output logic        o_enable_pc,
    output logic        o_enable_if,
    output logic        o_reset_if,
    output logic        o_enable_id,
    output logic        o_reset_id,
    output logic        o_stall_raw
);

    // The WB entry (index 2) only exists with a 3-deep tracker; write-first regfiles don't need it compared.
    localparam int NUM_CMP = (WB_WRITE_FIRST && (NUM_TRK > 2)) ? 2 : NUM_TRK;

    logic [NUM_TRK*TRK_W-1:0] trk_flat;
    trk_entry_t [NUM_TRK-1:0] trk;
    trk_entry_t               ins_entry;
    hz_mode_e                 mode;
    logic                     raw_hit;

    assign trk = trk_flat;

    always_comb begin
        raw_hit = 1'b0;
        for (int k = 0; k < NUM_TRK; k++) begin
            if (k < NUM_CMP) begin
                raw_hit = raw_hit
                    | (i_rs1_use_id && (i_rs1_addr_id != REG_X0) && rd_hit(trk[k], i_rs1_addr_id))
                    | (i_rs2_use_id && (i_rs2_addr_id != REG_X0) && rd_hit(trk[k], i_rs2_addr_id));
            end
        end
    end

    always_comb begin
        mode = HZ_RUN;
        if (i_mem_wait) begin
            mode = HZ_HOLD;
        end else if (i_pc_sel_ex) begin
            mode = HZ_FLUSH;
        end else if (raw_hit) begin
            mode = HZ_STALL;
        end
    end

    always_comb begin
        o_enable_pc = 1'b1;
        o_enable_if = 1'b1;
        o_reset_if  = 1'b1;
        o_enable_id = 1'b1;
        o_reset_id  = 1'b1;
        o_stall_raw = 1'b0;
        case (mode)
            HZ_HOLD: begin
                o_enable_pc = 1'b0;
                o_enable_if = 1'b0;
                o_enable_id = 1'b0;
            end
            HZ_FLUSH: begin
                o_reset_if = 1'b0;
                o_reset_id = 1'b0;
            end
            HZ_STALL: begin
                o_enable_pc = 1'b0;
                o_enable_if = 1'b0;
                o_reset_id  = 1'b0;
                o_stall_raw = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // x0 writes are architecturally discarded, so they never become a producer.
    always_comb begin
        ins_entry.vld = i_rd_wren_id && (i_rd_addr_id != REG_X0);
        ins_entry.rd  = i_rd_addr_id;
    end

    hazard_trk #(
        .NUM_TRK (NUM_TRK)
    ) u_trk (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_hold    (mode == HZ_HOLD),
        .i_bubble  (mode != HZ_RUN),
        .i_ins     (ins_entry),
        .o_entries (trk_flat)
    );

`ifdef HAZARD_PERF_EN
    logic [31:0] raw_cnt_q,   raw_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] hold_cnt_q,  hold_cnt_d;

    always_comb begin
        raw_cnt_d   = raw_cnt_q;
        flush_cnt_d = flush_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        if (i_perf_clr) begin
            raw_cnt_d   = '0;
            flush_cnt_d = '0;
            hold_cnt_d  = '0;
        end else begin
            case (mode)
                HZ_STALL: raw_cnt_d   = raw_cnt_q + 32'd1;
                HZ_FLUSH: flush_cnt_d = flush_cnt_q + 32'd1;
                HZ_HOLD:  hold_cnt_d  = hold_cnt_q + 32'd1;
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            raw_cnt_q   <= '0;
            flush_cnt_q <= '0;
            hold_cnt_q  <= '0;
        end else begin
            raw_cnt_q   <= raw_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign o_raw_cycles   = raw_cnt_q;
    assign o_flush_cycles = flush_cnt_q;
    assign o_hold_cycles  = hold_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a write-first instance and a WB-compare instance share the stimulus.
// Expected control vectors are queued when stimulus is driven and checked on the following negedge.
module tb_hazard_ctrl;

    // {enable_pc, enable_if, reset_if, enable_id, reset_id, stall_raw}
    localparam logic [5:0] RUN = 6'b111110;
    localparam logic [5:0] STL = 6'b001101;
    localparam logic [5:0] FLS = 6'b110100;
    localparam logic [5:0] HLD = 6'b001010;

    typedef struct {
        string      tag;
        logic [5:0] expA;
        logic [5:0] expB;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstN;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, wren, pcSel, memWait;

    logic enPcA, enIfA, rstIfA, enIdA, rstIdA, stallA;
    logic enPcB, enIfB, rstIfB, enIdB, rstIdB, stallB;

    exp_t sbq[$];
    int   nVectors = 0;
    int   nMis     = 0;

`ifdef HAZARD_PERF_EN
    logic        perfClr    = 1'b0;
    logic        perfClrReq = 1'b0;
    logic [31:0] rawA, flushA, holdA, rawB, flushB, holdB;
`endif

    always #5 clk = ~clk;

    hazard_ctrl dutA (
        .i_clk         (clk),
        .i_reset       (rstN),
        .i_rs1_addr_id (rs1),
        .i_rs2_addr_id (rs2),
        .i_rs1_use_id  (use1),
        .i_rs2_use_id  (use2),
        .i_rd_addr_id  (rd),
        .i_rd_wren_id  (wren),
        .i_pc_sel_ex   (pcSel),
        .i_mem_wait    (memWait),
`ifdef HAZARD_PERF_EN
        .i_perf_clr     (perfClr),
        .o_raw_cycles   (rawA),
        .o_flush_cycles (flushA),
        .o_hold_cycles  (holdA),
`endif
        .o_enable_pc   (enPcA),
        .o_enable_if   (enIfA),
        .o_reset_if    (rstIfA),
        .o_enable_id   (enIdA),
        .o_reset_id    (rstIdA),
        .o_stall_raw   (stallA)
    );

    hazard_ctrl #(
        .WB_WRITE_FIRST (1'b0)
    ) dutB (
        .i_clk         (clk),
        .i_reset       (rstN),
        .i_rs1_addr_id (rs1),
        .i_rs2_addr_id (rs2),
        .i_rs1_use_id  (use1),
        .i_rs2_use_id  (use2),
        .i_rd_addr_id  (rd),
        .i_rd_wren_id  (wren),
        .i_pc_sel_ex   (pcSel),
        .i_mem_wait    (memWait),
`ifdef HAZARD_PERF_EN
        .i_perf_clr     (perfClr),
        .o_raw_cycles   (rawB),
        .o_flush_cycles (flushB),
        .o_hold_cycles  (holdB),
`endif
        .o_enable_pc   (enPcB),
        .o_enable_if   (enIfB),
        .o_reset_if    (rstIfB),
        .o_enable_id   (enIdB),
        .o_reset_id    (rstIdB),
        .o_stall_raw   (stallB)
    );

    task automatic checkOutput();
        exp_t       e;
        logic [5:0] obsA;
        logic [5:0] obsB;
        if (sbq.size() == 0) begin
            nMis++;
            $display("[TB] FAIL scoreboard: got empty queue, required one pending vector");
            return;
        end
        e    = sbq.pop_front();
        obsA = {enPcA, enIfA, rstIfA, enIdA, rstIdA, stallA};
        obsB = {enPcB, enIfB, rstIfB, enIdB, rstIdB, stallB};
        nVectors++;
        assert (obsA === e.expA) else begin
            nMis++;
            $error("[TB] FAIL %s wbFirst: got %b required %b", e.tag, obsA, e.expA);
        end
        assert (obsB === e.expB) else begin
            nMis++;
            $error("[TB] FAIL %s wbCompare: got %b required %b", e.tag, obsB, e.expB);
        end
    endtask

    task automatic applyStimulus(
        input string      tag,
        input logic       r,
        input logic [4:0] s1, input logic u1,
        input logic [4:0] s2, input logic u2,
        input logic [4:0] d,  input logic w,
        input logic       br, input logic mw,
        input logic [5:0] expA, input logic [5:0] expB
    );
        exp_t e;
        @(posedge clk);
        #1;
        rstN    = r;
        rs1     = s1;  use1 = u1;
        rs2     = s2;  use2 = u2;
        rd      = d;   wren = w;
        pcSel   = br;  memWait = mw;
`ifdef HAZARD_PERF_EN
        perfClr = perfClrReq;
`endif
        e.tag  = tag;
        e.expA = expA;
        e.expB = expB;
        sbq.push_back(e);
        @(negedge clk);
        checkOutput();
    endtask

`ifdef HAZARD_PERF_EN
    task automatic checkPerf(input string tag, input logic [31:0] er, input logic [31:0] ef, input logic [31:0] eh);
        nVectors++;
        assert (rawA === er) else begin
            nMis++; $error("[TB] FAIL %s raw: got %0d required %0d", tag, rawA, er);
        end
        assert (flushA === ef) else begin
            nMis++; $error("[TB] FAIL %s flush: got %0d required %0d", tag, flushA, ef);
        end
        assert (holdA === eh) else begin
            nMis++; $error("[TB] FAIL %s hold: got %0d required %0d", tag, holdA, eh);
        end
        assert (rawB === er && flushB === ef && holdB === eh) else begin
            nMis++; $error("[TB] FAIL %s wbCompare counters: got %0d/%0d/%0d required %0d/%0d/%0d",
                           tag, rawB, flushB, holdB, er, ef, eh);
        end
    endtask
`endif

    initial begin
        rstN = 1'b0;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        use1 = 1'b0; use2 = 1'b0; wren = 1'b0; pcSel = 1'b0; memWait = 1'b0;

        //             tag            rst  rs1 u1  rs2 u2  rd  w   br  mw   A    B
        applyStimulus("reset",        0, 0,  0, 0,  0, 0,  0, 0,  0,   RUN, RUN);
        applyStimulus("idle",         1, 0,  0, 0,  0, 0,  0, 0,  0,   RUN, RUN);

        // Producer x5 then a dependent consumer held in ID
        applyStimulus("prod_x5",      1, 0,  0, 0,  0, 5,  1, 0,  0,   RUN, RUN);
        applyStimulus("cons_x5_c1",   1, 5,  1, 0,  0, 6,  0, 0,  0,   STL, STL);
        applyStimulus("cons_x5_c2",   1, 5,  1, 0,  0, 6,  0, 0,  0,   STL, STL);
        applyStimulus("cons_x5_c3",   1, 5,  1, 0,  0, 6,  0, 0,  0,   RUN, STL);
        applyStimulus("after_x5",     1, 0,  0, 0,  0, 0,  0, 0,  0,   RUN, RUN);

        // x0 is never a hazard
        applyStimulus("prod_x0",      1, 0,  0, 0,  0, 0,  1, 0,  0,   RUN, RUN);
        applyStimulus("cons_x0",      1, 0,  1, 0,  1, 0,  0, 0,  0,   RUN, RUN);

        // Branch resolved while a RAW stall is pending: flush wins
        applyStimulus("prod_x7",      1, 0,  0, 0,  0, 7,  1, 0,  0,   RUN, RUN);
        applyStimulus("cons_x7_rs2",  1, 0,  0, 7,  1, 0,  0, 0,  0,   STL, STL);
        applyStimulus("flush_raw",    1, 0,  0, 7,  1, 9,  1, 1,  0,   FLS, FLS);
        applyStimulus("no_wrongpath", 1, 9,  1, 0,  0, 0,  0, 0,  0,   RUN, RUN);
        applyStimulus("idle2",        1, 0,  0, 0,  0, 0,  0, 0,  0,   RUN, RUN);

        // Memory wait freezes a pending stall without consuming it
        applyStimulus("prod_x10",     1, 0,  0, 0,  0, 10, 1, 0,  0,   RUN, RUN);
        applyStimulus("cons_x10_c1",  1, 10, 1, 0,  0, 0,  0, 0,  0,   STL, STL);
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("hold_%0d", i), 1, 10, 1, 0, 0, 0, 0, 0, 1, HLD, HLD);
        end
        applyStimulus("cons_x10_c2",  1, 10, 1, 0,  0, 0,  0, 0,  0,   STL, STL);
        applyStimulus("cons_x10_c3",  1, 10, 1, 0,  0, 0,  0, 0,  0,   RUN, STL);
        applyStimulus("idle3",        1, 0,  0, 0,  0, 0,  0, 0,  0,   RUN, RUN);

`ifdef HAZARD_PERF_EN
        perfClrReq = 1'b1;
        applyStimulus("perf_clr0",    1, 0,  0, 0,  0, 0,  0, 0,  0,   RUN, RUN);
        perfClrReq = 1'b0;
        applyStimulus("perf_prod",    1, 0,  0, 0,  0, 12, 1, 0,  0,   RUN, RUN);
        applyStimulus("perf_stl1",    1, 12, 1, 0,  0, 0,  0, 0,  0,   STL, STL);
        applyStimulus("perf_stl2",    1, 12, 1, 0,  0, 0,  0, 0,  0,   STL, STL);
        applyStimulus("perf_fls",     1, 12, 1, 0,  0, 0,  0, 1,  0,   FLS, FLS);
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("perf_hold_%0d", i), 1, 0, 0, 0, 0, 0, 0, 0, 1, HLD, HLD);
        end
        perfClrReq = 1'b1;
        applyStimulus("perf_idle",    1, 0,  0, 0,  0, 0,  0, 0,  0,   RUN, RUN);
        checkPerf("perf_counts", 32'd2, 32'd1, 32'd4);
        perfClrReq = 1'b0;
        applyStimulus("perf_cleared", 1, 0,  0, 0,  0, 0,  0, 0,  0,   RUN, RUN);
        checkPerf("perf_clr", 32'd0, 32'd0, 32'd0);
`endif

        // Reset in the middle of a stall clears the tracker immediately
        applyStimulus("prod_x11",     1, 0,  0, 0,  0, 11, 1, 0,  0,   RUN, RUN);
        applyStimulus("cons_x11",     1, 11, 1, 0,  0, 0,  0, 0,  0,   STL, STL);
        applyStimulus("reset_mid",    0, 11, 1, 0,  0, 0,  0, 0,  0,   RUN, RUN);
        applyStimulus("post_reset",   1, 11, 1, 0,  0, 0,  0, 0,  0,   RUN, RUN);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMis);
        $finish;
    end

endmodule
